cpu_run_ctrl: RTL and testbench

Parametrised execution controller that replaces the plain work-gated clock of the single-cycle core top. It produces a synchronous clock-enable (core_en) instead of a gated clock, and adds single-step, N-instruction burst, hardware PC breakpoints, external halt and a retired-instruction counter. It sits in the processor top between the run/debug inputs and the enable pins of the datapath (main) and control instances.

---
 rtl/cpu_run_pkg.sv | 15 +
 rtl/bp_match_unit.sv | 20 ++
 rtl/cpu_run_ctrl.sv | 117 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared state encoding and halt-cause codes for the run controller
package cpu_run_pkg;

    typedef enum logic [2:0] {IDLE, RUN, STEP, BURST, HALTED} run_state_e;

    localparam int CAUSE_W = 3;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE       = 3'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_STEP_DONE  = 3'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_BURST_DONE = 3'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BP         = 3'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_HALT_REQ   = 3'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_WORK_LOW   = 3'd5;

endpackage

// File: rtl/bp_match_unit.sv
// bp_match_unit: parallel PC breakpoint comparators OR-reduced into one match flag
module bp_match_unit #(
    parameter int PC_W   = 8,
    parameter int NUM_BP = 2
) (
    input  logic [PC_W-1:0]        pc,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    output logic                   bp_match
);

    logic [NUM_BP-1:0] hit;

    for (genvar i = 0; i < NUM_BP; i++) begin : g_cmp
        assign hit[i] = bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pc);
    end

    assign bp_match = |hit;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: clock-enable execution controller with step, burst, breakpoints, halt and retire counter
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int CNT_W  = 16,
    parameter int NUM_BP = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   work,
    input  logic                   step_req,
    input  logic                   burst_req,
    input  logic [CNT_W-1:0]       burst_len,
    input  logic                   halt_req,
    input  logic                   clr_halt,
    input  logic                   cnt_clr,
    input  logic [PC_W-1:0]        pc,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    output logic                   core_en,
    output logic                   running,
    output logic                   halted,
    output logic [CAUSE_W-1:0]     halt_cause,
    output logic [CNT_W-1:0]       retired_cnt
);

    run_state_e         state, state_nxt;
    logic [CNT_W-1:0]   remaining, remaining_nxt;
    logic [CAUSE_W-1:0] cause_nxt;
    logic               skip_bp, skip_set, bp_match, bp_hit;

    bp_match_unit #(.PC_W(PC_W), .NUM_BP(NUM_BP)) u_bp (
        .pc       (pc),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .bp_match (bp_match)
    );

    assign bp_hit  = bp_match && !skip_bp;
    assign running = state inside {RUN, STEP, BURST};
    assign halted  = state == HALTED;
    // RUN checks work before retiring, so dropping work retires nothing that cycle
    assign core_en = running && !halt_req && !(bp_hit && state != STEP) && !(state == RUN && !work);
    assign skip_set = halted && state_nxt != HALTED && halt_cause == CAUSE_BP;

    always_comb begin
        state_nxt     = state;
        cause_nxt     = halt_cause;
        remaining_nxt = remaining;
        case (state)
            IDLE: begin
                if (halt_req) begin
                    state_nxt = HALTED;
                    cause_nxt = CAUSE_HALT_REQ;
                end else if (step_req) begin
                    state_nxt = STEP;
                end else if (burst_req && burst_len != '0) begin
                    state_nxt     = BURST;
                    remaining_nxt = burst_len;
                end else if (work) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (halt_req || bp_hit) begin
                    state_nxt = HALTED;
                    cause_nxt = halt_req ? CAUSE_HALT_REQ : CAUSE_BP;
                end else if (!work) begin
                    state_nxt = IDLE;
                    cause_nxt = CAUSE_WORK_LOW;
                end
            end
            STEP: begin
                state_nxt = halt_req ? HALTED : IDLE;
                cause_nxt = halt_req ? CAUSE_HALT_REQ : CAUSE_STEP_DONE;
            end
            BURST: begin
                if (halt_req || bp_hit) begin
                    state_nxt = HALTED;
                    cause_nxt = halt_req ? CAUSE_HALT_REQ : CAUSE_BP;
                end else begin
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == 1) begin
                        state_nxt = IDLE;
                        cause_nxt = CAUSE_BURST_DONE;
                    end
                end
            end
            HALTED: begin
                if (!halt_req && step_req) begin
                    state_nxt = STEP;
                end else if (!halt_req && clr_halt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            halt_cause  <= CAUSE_NONE;
            remaining   <= '0;
            skip_bp     <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state       <= state_nxt;
            halt_cause  <= cause_nxt;
            remaining   <= remaining_nxt;
            skip_bp     <= skip_set ? 1'b1 : core_en ? 1'b0 : skip_bp;
            retired_cnt <= cnt_clr ? '0 : (core_en && !(&retired_cnt)) ? retired_cnt + 1'b1 : retired_cnt;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized scenario bench checked against instruction-count arithmetic
module tb_cpu_run_ctrl;

    localparam int PC_W   = 8;
    localparam int CNT_W  = 8;
    localparam int NUM_BP = 2;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   work, step_req, burst_req, halt_req, clr_halt, cnt_clr;
    logic [CNT_W-1:0]       burst_len;
    logic [PC_W-1:0]        pc;
    logic [NUM_BP-1:0]      bp_en;
    logic [NUM_BP*PC_W-1:0] bp_addr;
    logic                   core_en, running, halted;
    logic [2:0]             halt_cause;
    logic [CNT_W-1:0]       retired_cnt;

    int  errors = 0;
    int  checks = 0;
    int  n_en = 0;
    int  since_clr = 0;
    bit  last_en;

    cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .NUM_BP(NUM_BP)) dut (
        .clk         (clk),
        .rst         (rst),
        .work        (work),
        .step_req    (step_req),
        .burst_req   (burst_req),
        .burst_len   (burst_len),
        .halt_req    (halt_req),
        .clr_halt    (clr_halt),
        .cnt_clr     (cnt_clr),
        .pc          (pc),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .core_en     (core_en),
        .running     (running),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    function automatic int exp_cnt();
        return since_clr > MAXC ? MAXC : since_clr;
    endfunction

    // one clock: observe enable mid-cycle, then advance the core's pc model if it retired
    task automatic cycle();
        #3;
        last_en = core_en;
        if (core_en) n_en++;
        if (cnt_clr) since_clr = 0;
        else if (core_en) since_clr++;
        @(posedge clk);
        #1;
        if (last_en) pc = pc + 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL reset_core_en got=%b exp=0", core_en); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (halt_cause !== 3'd0) begin errors++; $display("FAIL reset_cause got=%0d exp=0", halt_cause); end
        checks++; if (retired_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", retired_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_run();
        for (int r = 0; r < 3; r++) begin
            int n, e0;
            n  = (r == 0) ? 5 : $urandom_range(1, 9);
            e0 = n_en;
            work = 1'b1;
            cycle();
            checks++; if (last_en !== 1'b0) begin errors++; $display("FAIL run_latency got=%b exp=0", last_en); end
            repeat (n) cycle();
            work = 1'b0;
            cycle();
            checks++; if (n_en - e0 != n) begin errors++; $display("FAIL run_en_count got=%0d exp=%0d", n_en - e0, n); end
            checks++; if (retired_cnt !== CNT_W'(exp_cnt())) begin errors++; $display("FAIL run_cnt got=%0d exp=%0d", retired_cnt, exp_cnt()); end
            checks++; if (halt_cause !== 3'd5) begin errors++; $display("FAIL run_cause got=%0d exp=5", halt_cause); end
            checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_running got=%b exp=0", running); end
        end
    endtask

    task automatic test_step();
        int e0;
        e0 = n_en;
        step_req = 1'b1;
        cycle();
        cycle();
        step_req = 1'b0;
        repeat (3) cycle();
        checks++; if (n_en - e0 != 1) begin errors++; $display("FAIL step_en_count got=%0d exp=1", n_en - e0); end
        checks++; if (retired_cnt !== CNT_W'(exp_cnt())) begin errors++; $display("FAIL step_cnt got=%0d exp=%0d", retired_cnt, exp_cnt()); end
        checks++; if (halt_cause !== 3'd1) begin errors++; $display("FAIL step_cause got=%0d exp=1", halt_cause); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL step_running got=%b exp=0", running); end
    endtask

    task automatic test_burst();
        int e0;
        for (int r = 0; r < 4; r++) begin
            int len;
            len = (r == 0) ? 3 : $urandom_range(1, 12);
            e0  = n_en;
            burst_req = 1'b1;
            burst_len = CNT_W'(len);
            cycle();
            burst_req = 1'b0;
            burst_len = CNT_W'($urandom);
            for (int k = 0; k < len + 3; k++) begin
                burst_req = (k == 1 && len >= 3);
                step_req  = (k == 2 && len >= 4);
                cycle();
            end
            burst_req = 1'b0;
            step_req  = 1'b0;
            checks++; if (n_en - e0 != len) begin errors++; $display("FAIL burst_en_count len=%0d got=%0d exp=%0d", len, n_en - e0, len); end
            checks++; if (halt_cause !== 3'd2) begin errors++; $display("FAIL burst_cause got=%0d exp=2", halt_cause); end
            checks++; if (retired_cnt !== CNT_W'(exp_cnt())) begin errors++; $display("FAIL burst_cnt got=%0d exp=%0d", retired_cnt, exp_cnt()); end
        end
        e0 = n_en;
        burst_req = 1'b1;
        burst_len = '0;
        cycle();
        burst_req = 1'b0;
        repeat (2) cycle();
        checks++; if (n_en - e0 != 0) begin errors++; $display("FAIL burst_zero_en got=%0d exp=0", n_en - e0); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL burst_zero_running got=%b exp=0", running); end
    endtask

    task automatic test_breakpoint();
        for (int r = 0; r < 3; r++) begin
            int a, j, c0;
            a  = (r == 0) ? 4 : $urandom_range(1, 12);
            j  = (r == 0) ? 0 : $urandom_range(0, 1);
            pc = '0;
            bp_en = '0;
            bp_en[j] = 1'b1;
            bp_addr[j*PC_W +: PC_W] = PC_W'(a);
            bp_addr[(1-j)*PC_W +: PC_W] = 8'd200;
            if (r == 2) bp_en = 2'b11;
            c0 = since_clr;
            work = 1'b1;
            cycle();
            for (int k = 0; k < 40 && !halted; k++) cycle();
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL bp_halted addr=%0d got=%b exp=1", a, halted); end
            checks++; if (last_en !== 1'b0) begin errors++; $display("FAIL bp_core_en got=%b exp=0", last_en); end
            checks++; if (pc !== PC_W'(a)) begin errors++; $display("FAIL bp_pc got=%0d exp=%0d", pc, a); end
            checks++; if (halt_cause !== 3'd3) begin errors++; $display("FAIL bp_cause got=%0d exp=3", halt_cause); end
            checks++; if (since_clr - c0 != a || retired_cnt !== CNT_W'(exp_cnt())) begin errors++; $display("FAIL bp_cnt got=%0d exp=%0d", retired_cnt, c0 + a); end
            work = 1'b0;
            clr_halt = 1'b1;
            cycle();
            clr_halt = 1'b0;
            work = 1'b1;
            cycle();
            repeat (3) cycle();
            checks++; if (pc !== PC_W'(a + 3) || halted !== 1'b0) begin errors++; $display("FAIL bp_resume pc=%0d halted=%b exp pc=%0d halted=0", pc, halted, a + 3); end
            work = 1'b0;
            cycle();
        end
        bp_en = '0;
    endtask

    task automatic test_halt();
        burst_req = 1'b1;
        burst_len = CNT_W'(5);
        cycle();
        burst_req = 1'b0;
        repeat (3) cycle();
        halt_req = 1'b1;
        #1;
        checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL halt_core_en got=%b exp=0", core_en); end
        cycle();
        checks++; if (halted !== 1'b1 || halt_cause !== 3'd4) begin errors++; $display("FAIL halt_state halted=%b cause=%0d exp 1/4", halted, halt_cause); end
        checks++; if (dut.remaining !== CNT_W'(2)) begin errors++; $display("FAIL halt_remaining got=%0d exp=2", dut.remaining); end
        clr_halt = 1'b1;
        cycle();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_block got=%b exp=1", halted); end
        halt_req = 1'b0;
        cycle();
        clr_halt = 1'b0;
        checks++; if (halted !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL halt_clear halted=%b running=%b exp 0/0", halted, running); end
    endtask

    task automatic test_saturate();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        work = 1'b1;
        cycle();
        repeat (MAXC + 5) cycle();
        checks++; if (retired_cnt !== CNT_W'(exp_cnt())) begin errors++; $display("FAIL sat_cnt got=%0d exp=%0d", retired_cnt, exp_cnt()); end
        cnt_clr = 1'b1;
        cycle();
        checks++; if (last_en !== 1'b1 || retired_cnt !== '0) begin errors++; $display("FAIL sat_clr en=%b cnt=%0d exp 1/0", last_en, retired_cnt); end
        cnt_clr = 1'b0;
        cycle();
        checks++; if (retired_cnt !== CNT_W'(exp_cnt())) begin errors++; $display("FAIL sat_after_clr got=%0d exp=%0d", retired_cnt, exp_cnt()); end
        work = 1'b0;
        cycle();
    endtask

    task automatic test_async_reset();
        burst_req = 1'b1;
        burst_len = CNT_W'(10);
        cycle();
        burst_req = 1'b0;
        repeat (3) cycle();
        #3;
        rst = 1'b0;
        #1;
        checks++; if (core_en !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL async_rst en=%b running=%b exp 0/0", core_en, running); end
        checks++; if (retired_cnt !== '0) begin errors++; $display("FAIL async_rst_cnt got=%0d exp=0", retired_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        since_clr = 0;
        cycle();
        checks++; if (running !== 1'b0 || halt_cause !== 3'd0) begin errors++; $display("FAIL async_rst_after running=%b cause=%0d exp 0/0", running, halt_cause); end
    endtask

    initial begin
        rst = 1'b0;
        {work, step_req, burst_req, halt_req, clr_halt, cnt_clr} = '0;
        burst_len = '0;
        pc = '0;
        bp_en = '0;
        bp_addr = '0;
        test_reset();
        test_run();
        test_step();
        test_burst();
        test_breakpoint();
        test_halt();
        test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
